axis_rr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter: merges N AXI4-Stream sources onto one AXI4-Stream sink.
//  The grant is held from the first beat of a packet until its TLAST handshake.

---
 rtl/axis_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin merge of N AXI4-Stream sources onto one sink; 1-cycle arbitration, zero-latency PASS path.
// Backpressure: M_TREADY is forwarded combinationally to the granted source only; grant held until TLAST (or truncation).
module axis_rr_arbiter #(
    parameter int N         = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [N-1:0]               EN,
    input  logic [N-1:0]               S_TVALID,
    output logic [N-1:0]               S_TREADY,
    input  logic [N*DATA_W-1:0]        S_TDATA,
    input  logic [N*(DATA_W/8)-1:0]    S_TKEEP,
    input  logic [N-1:0]               S_TLAST,
    output logic                       M_TVALID,
    input  logic                       M_TREADY,
    output logic [DATA_W-1:0]          M_TDATA,
    output logic [(DATA_W/8)-1:0]      M_TKEEP,
    output logic                       M_TLAST,
    output logic [N-1:0]               GRANT,
    output logic                       TRUNC
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int PW     = $clog2(N);
    localparam logic TRUNC_EN = (MAX_BEATS != 0);
    localparam logic [15:0] LAST_CNT = (MAX_BEATS == 0) ? 16'd0 : 16'(MAX_BEATS - 1);

    typedef enum logic {ARB, PASS} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       gidx;
    logic [PW-1:0]       pick;
    logic [N-1:0]        gnt;
    logic [N-1:0]        req;
    logic [15:0]         cnt;
    logic                trunc_q;
    logic                found;
    logic                in_pass;
    logic                sel_vld;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                cut;
    logic                beat;
    logic                pkt_end;

    assign req = S_TVALID & EN;

    // Rotating priority search starting at ptr, wrapping at N (not at 2**PW).
    always_comb begin : rr_search
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_vld  = S_TVALID[gidx];
        sel_last = S_TLAST[gidx];
        sel_data = S_TDATA[int'(gidx)*DATA_W +: DATA_W];
        sel_keep = S_TKEEP[int'(gidx)*KEEP_W +: KEEP_W];
    end

    assign in_pass = (state == PASS);
    assign cut     = TRUNC_EN && (cnt == LAST_CNT);
    assign beat    = in_pass && sel_vld && M_TREADY;
    assign pkt_end = beat && (sel_last || cut);

    assign M_TVALID = in_pass && sel_vld;
    assign M_TDATA  = sel_data;
    assign M_TKEEP  = sel_keep;
    assign M_TLAST  = in_pass && (sel_last || cut);
    assign S_TREADY = in_pass ? (gnt & {N{M_TREADY}}) : '0;
    assign GRANT    = gnt;
    assign TRUNC    = trunc_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= ARB;
            ptr     <= '0;
            gidx    <= '0;
            gnt     <= '0;
            cnt     <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            case (state)
                ARB: begin
                    if (found) begin
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << pick;
                        gidx  <= pick;
                        cnt   <= '0;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (pkt_end) begin
                        state   <= ARB;
                        gnt     <= '0;
                        cnt     <= '0;
                        ptr     <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
                        // Only a cut that overrides a non-last beat counts as truncation.
                        trunc_q <= cut && !sel_last;
                    end else if (beat) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-source expected queues, packet grant log, plus an N=3 rotation instance.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int MB = 4;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [N-1:0]    EN, S_TVALID, S_TREADY, S_TLAST, GRANT;
    logic [N*DW-1:0] S_TDATA;
    logic [N*KW-1:0] S_TKEEP;
    logic            M_TVALID, M_TREADY, M_TLAST, TRUNC;
    logic [DW-1:0]   M_TDATA;
    logic [KW-1:0]   M_TKEEP;

    logic            rst3;
    logic [2:0]      en3, s3_vld, s3_rdy, s3_last, m3_gnt;
    logic [23:0]     s3_data;
    logic [2:0]      s3_keep;
    logic            m3_vld, m3_rdy, m3_last, m3_trunc;
    logic [7:0]      m3_data;
    logic [0:0]      m3_keep;

    always #5 ACLK = ~ACLK;

    axis_rr_arbiter #(.N(N), .DATA_W(DW), .MAX_BEATS(MB)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .EN(EN),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
        .GRANT(GRANT), .TRUNC(TRUNC)
    );

    axis_rr_arbiter #(.N(3), .DATA_W(8), .MAX_BEATS(0)) u_dut3 (
        .ACLK(ACLK), .ARESET(rst3), .EN(en3),
        .S_TVALID(s3_vld), .S_TREADY(s3_rdy), .S_TDATA(s3_data), .S_TKEEP(s3_keep), .S_TLAST(s3_last),
        .M_TVALID(m3_vld), .M_TREADY(m3_rdy), .M_TDATA(m3_data), .M_TKEEP(m3_keep), .M_TLAST(m3_last),
        .GRANT(m3_gnt), .TRUNC(m3_trunc)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t         src_q[N][$];
    beat_t         exp_q[N][$];
    int            gnt_log[$];
    int            start_log[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            trunc_cnt = 0;
    int            stall_cnt = 0;
    int            last_end = -100;
    bit            in_pkt = 1'b0;
    bit            stalled = 1'b0;
    logic [DW-1:0] stall_dat;
    logic [N-1:0]  hs = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Expected TLAST also marks every MB-th beat of a segment, since the arbiter cuts there.
    task automatic send(input int s, input int len, input int base);
        for (int p = 0; p < len; p++) begin
            beat_t b, e;
            b.d = DW'(base + p);
            b.k = (p == len - 1) ? 4'h3 : 4'hF;
            b.l = (p == len - 1);
            e   = b;
            e.l = (p == len - 1) || (p % MB == MB - 1);
            src_q[s].push_back(b);
            exp_q[s].push_back(e);
        end
    endtask

    function automatic bit all_empty();
        int n = 0;
        for (int i = 0; i < N; i++) n += src_q[i].size() + exp_q[i].size();
        return (n == 0);
    endfunction

    function automatic int log_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(all_empty() && !in_pkt) && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        chk(tag, all_empty() && !in_pkt, 1);
        @(negedge ACLK);
        #1;
    endtask

    always @(posedge ACLK) cyc++;

    // Source model: a beat leaves its queue only after a seen handshake.
    initial begin
        S_TVALID = '0; S_TDATA = '0; S_TKEEP = '0; S_TLAST = '0;
        forever begin
            @(posedge ACLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    S_TVALID[i]            = 1'b1;
                    S_TDATA[i*DW +: DW]    = src_q[i][0].d;
                    S_TKEEP[i*KW +: KW]    = src_q[i][0].k;
                    S_TLAST[i]             = src_q[i][0].l;
                end else begin
                    S_TVALID[i] = 1'b0;
                    S_TLAST[i]  = 1'b0;
                end
            end
            hs = '0;
        end
    end

    always @(negedge ACLK) begin
        int src;
        beat_t e;
        hs = S_TVALID & S_TREADY;
        if (TRUNC) trunc_cnt++;
        if (!ARESET) begin
            chk("rdy_mirror", S_TREADY, GRANT & {N{M_TREADY}});
            chk("idle_vld", M_TVALID && (GRANT == '0), 0);
            if (stalled) begin
                chk("stall_vld", M_TVALID, 1);
                chk("stall_dat", M_TDATA, stall_dat);
            end
            stalled   = M_TVALID && !M_TREADY;
            stall_dat = M_TDATA;
            if (stalled) stall_cnt++;
            if (M_TVALID && M_TREADY) begin
                chk("gnt_onehot", $countones(GRANT), 1);
                src = oh2i(GRANT);
                if (!in_pkt) begin
                    chk("pkt_gap", (cyc - last_end) >= 2, 1);
                    gnt_log.push_back(src);
                    start_log.push_back(cyc);
                end
                chk("beat_expected", (src >= 0) && (exp_q[src].size() != 0), 1);
                if (src >= 0 && exp_q[src].size() != 0) begin
                    e = exp_q[src].pop_front();
                    chk("m_data", M_TDATA, e.d);
                    chk("m_keep", M_TKEEP, e.k);
                    chk("m_last", M_TLAST, e.l);
                end
                in_pkt = !M_TLAST;
                if (M_TLAST) last_end = cyc;
            end
        end else begin
            in_pkt  = 1'b0;
            stalled = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, t0, s0;
        bit rdy_pat [4];
        rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b1};
        ARESET = 1'b1; rst3 = 1'b1; EN = '1; M_TREADY = 1'b1;
        en3 = 3'b111; s3_vld = 3'b111; s3_last = 3'b111; s3_data = 24'h030201; s3_keep = 3'b111; m3_rdy = 1'b1;

        repeat (2) @(negedge ACLK);
        chk("rst_vld", M_TVALID, 0);
        chk("rst_rdy", S_TREADY, 0);
        chk("rst_gnt", GRANT, 0);
        chk("rst_trunc", TRUNC, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("idle_gnt", GRANT, 0);

        // single source, 3 beats
        send(2, 3, 1);
        @(posedge ACLK); #2;
        chk("t1_vld_up", S_TVALID[2], 1);
        chk("t1_gnt_arb", GRANT, 0);
        @(posedge ACLK); #2;
        chk("t1_gnt", GRANT, 4'b0100);
        wait_idle(50, "t1_drain");
        chk("t1_log", log_at(0), 2);
        chk("t1_idle", M_TVALID, 0);
        gnt_log.delete(); start_log.delete();

        // ptr is 3 now: src3 beats src2
        send(3, 1, 100); send(2, 1, 200);
        wait_idle(50, "tp_drain");
        chk("tp_log0", log_at(0), 3);
        chk("tp_log1", log_at(1), 2);
        send(3, 1, 300);
        wait_idle(50, "tp_drain2");
        gnt_log.delete(); start_log.delete();

        // all sources busy from ptr 0
        send(0, 2, 10); send(1, 2, 20); send(2, 2, 30); send(3, 2, 40); send(0, 2, 50);
        wait_idle(100, "t2_drain");
        chk("t2_npkt", gnt_log.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), log_at(i), i % N);
        chk("t2_span", (start_log.size() > 0) ? last_end - start_log[0] : -1, 13);
        gnt_log.delete(); start_log.delete();

        // masked source
        send(1, 1, 60);
        wait_idle(50, "t3_pre");
        gnt_log.delete(); start_log.delete();
        EN = 4'b1011;
        send(2, 2, 70); send(3, 2, 80);
        repeat (15) @(negedge ACLK);
        #1;
        chk("t3_src3_done", exp_q[3].size(), 0);
        chk("t3_src2_wait", exp_q[2].size(), 2);
        chk("t3_src2_rdy", S_TREADY[2], 0);
        chk("t3_log0", log_at(0), 3);
        EN = '1;
        wait_idle(50, "t3_drain");
        chk("t3_log1", log_at(1), 2);
        gnt_log.delete(); start_log.delete();

        // truncation at MB beats
        t0 = trunc_cnt;
        send(0, 6, 90);
        wait_idle(60, "t4_drain");
        chk("t4_trunc", trunc_cnt - t0, 1);
        chk("t4_npkt", gnt_log.size(), 2);
        chk("t4_log1", log_at(1), 0);
        gnt_log.delete(); start_log.delete();
        t0 = trunc_cnt;
        send(1, 4, 110);
        wait_idle(60, "t4b_drain");
        chk("t4b_trunc", trunc_cnt - t0, 0);
        chk("t4b_npkt", gnt_log.size(), 1);
        gnt_log.delete(); start_log.delete();

        // backpressure
        s0 = stall_cnt;
        send(1, 3, 120);
        n = 0;
        while (GRANT[1] !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
        chk("t5_granted", GRANT[1], 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            M_TREADY = rdy_pat[i];
        end
        wait_idle(50, "t5_drain");
        chk("t5_stalls", stall_cnt - s0, 2);
        gnt_log.delete(); start_log.delete();

        // reset during beat 2 of 4
        send(0, 4, 130);
        n = 0;
        while (exp_q[0].size() != 3 && n < 20) begin @(negedge ACLK); #1; n++; end
        chk("t6_beat1", exp_q[0].size(), 3);
        @(posedge ACLK);
        @(negedge ACLK); #2;
        chk("t6_pre_gnt", GRANT, 4'b0001);
        ARESET = 1'b1;
        #1;
        chk("t6_rdy", S_TREADY, 0);
        chk("t6_vld", M_TVALID, 0);
        chk("t6_gnt", GRANT, 0);
        for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        gnt_log.delete(); start_log.delete();
        @(negedge ACLK);
        chk("t6_post_gnt", GRANT, 0);
        send(1, 1, 140); send(0, 1, 150);
        wait_idle(50, "t6_drain");
        chk("t6_tie0", log_at(0), 0);
        chk("t6_tie1", log_at(1), 1);

        // N=3 rotation wraps 2 -> 0
        @(negedge ACLK);
        rst3 = 1'b0;
        k = 0; n = 0;
        while (k < 6 && n < 40) begin
            @(negedge ACLK);
            n++;
            if (m3_gnt != 3'b000) begin
                chk($sformatf("n3_gnt%0d", k), m3_gnt, 3'b001 << (k % 3));
                chk($sformatf("n3_data%0d", k), m3_data, k % 3 + 1);
                k++;
            end
        end
        chk("n3_count", k, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
